// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave controller.
package spi_slv_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        STORE,
        DONE
    } statetype;

    localparam int DATA_W_C    = 8;
    localparam int BIT_CNT_W   = 3;
    localparam int SYNC_STAGES = 2;

    // Pin slots in the synchronizer array
    localparam int PIN_SCLK = 0;
    localparam int PIN_CS_N = 1;
    localparam int PIN_MOSI = 2;
    localparam int NUM_PINS = 3;

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Data-register bus between the SPI slave controller (master side)
// and the register file (slave side). Read data has 1-cycle latency.
interface spi_slave_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] rd_data_i;
    logic [DATA_W-1:0] wr_data_o;
    logic              we_o;

    modport master (output addr_o, output wr_data_o, output we_o, input rd_data_i);
    modport slave  (input addr_o, input wr_data_o, input we_o, output rd_data_i);
endinterface

// File: rtl/spi_slv_sync.sv
// Multi-flop synchronizer for one asynchronous pin plus edge detect.
// RST_VAL is the idle level of the pin so reset never fakes an edge.
module spi_slv_sync
    import spi_slv_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain followed by one flop of history for edges
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] &  prev_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 slave controller, 8-bit frames. Each byte is fetched from
// the data register at the byte index and the received byte is written
// back to the same index.
// Build option: SPI_SLV_LSB_FIRST_EN selects LSB-first bit order.
module spi_slave_ctrl
    import spi_slv_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = DATA_W_C
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              sclk_i,
    input  logic              cs_n_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [ADDR_W-1:0] cuenta_o,
    output logic              busy_o,
    output logic              done_o,
    spi_slave_ctrl_if.master  reg_bus
);
    localparam logic [NUM_PINS-1:0] PIN_IDLE = 3'b010; // cs_n idles high

    logic [NUM_PINS-1:0] pin_raw, pin_sync, pin_rise, pin_fall;
    assign pin_raw = {mosi_i, cs_n_i, sclk_i};

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_sync
        spi_slv_sync #(.RST_VAL(PIN_IDLE[i])) u_sync (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .d_i    (pin_raw[i]),
            .sync_o (pin_sync[i]),
            .rise_o (pin_rise[i]),
            .fall_o (pin_fall[i])
        );
    end

    logic sclk_rise, sclk_fall, cs_n_sync, cs_fall, mosi_sync;
    assign sclk_rise = pin_rise[PIN_SCLK];
    assign sclk_fall = pin_fall[PIN_SCLK];
    assign cs_n_sync = pin_sync[PIN_CS_N];
    assign cs_fall   = pin_fall[PIN_CS_N];
    assign mosi_sync = pin_sync[PIN_MOSI];

    logic unused_edges;
    assign unused_edges = ^{pin_sync[PIN_SCLK], pin_rise[PIN_CS_N], pin_rise[PIN_MOSI], pin_fall[PIN_MOSI]};

    statetype             state;
    logic [DATA_W-1:0]    shift_reg, rx_reg, rx_next, shift_next;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wr_data_q;
    logic                 we_q;
    logic                 abort;

    // Deselect or disable ends the transaction; level-based so a rise that
    // lands during STORE is still seen once the write has gone out.
    assign abort = cs_n_sync | ~en_i;

`ifdef SPI_SLV_LSB_FIRST_EN
    assign rx_next    = {mosi_sync, rx_reg[DATA_W-1:1]};
    assign shift_next = {1'b0, shift_reg[DATA_W-1:1]};
    assign miso_o     = shift_reg[0];
`else
    assign rx_next    = {rx_reg[DATA_W-2:0], mosi_sync};
    assign shift_next = {shift_reg[DATA_W-2:0], 1'b0};
    assign miso_o     = shift_reg[DATA_W-1];
`endif

    assign miso_oe_o         = en_i & ~cs_n_sync;
    assign reg_bus.addr_o    = addr_q;
    assign reg_bus.wr_data_o = wr_data_q;
    assign reg_bus.we_o      = we_q;

    // Transaction FSM with registered bus/status outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            shift_reg <= '0;
            rx_reg    <= '0;
            bit_cnt   <= '0;
            cuenta_o  <= '0;
            addr_q    <= '0;
            wr_data_q <= '0;
            we_q      <= 1'b0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (en_i && cs_fall) begin
                        state    <= FETCH;
                        cuenta_o <= '0;
                        bit_cnt  <= '0;
                        addr_q   <= '0;
                        busy_o   <= 1'b1;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        shift_reg <= reg_bus.rd_data_i;
                        bit_cnt   <= '0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (abort) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else if (sclk_rise) begin
                        rx_reg  <= rx_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_W'(DATA_W - 1)) begin
                            state     <= STORE;
                            addr_q    <= cuenta_o;
                            wr_data_q <= rx_next;
                            we_q      <= 1'b1;
                        end
                    end else if (sclk_fall && bit_cnt != '0) begin
                        shift_reg <= shift_next;
                    end
                end
                STORE: begin
                    cuenta_o <= cuenta_o + 1'b1;
                    if (abort) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        state  <= FETCH;
                        addr_q <= cuenta_o + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: register-file model on the bus and
// a bit-banged SPI master with a 20-clock sclk period.
module tb_spi_slave_ctrl;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst, en, sclk, cs_n, mosi;
    logic miso, miso_oe, busy, done;
    logic [ADDR_W-1:0] cuenta;

    spi_slave_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    spi_slave_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .sclk_i    (sclk),
        .cs_n_i    (cs_n),
        .mosi_i    (mosi),
        .miso_o    (miso),
        .miso_oe_o (miso_oe),
        .cuenta_o  (cuenta),
        .busy_o    (busy),
        .done_o    (done),
        .reg_bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Register file model plus write/done monitors
    logic [7:0]        mem [0:(1<<ADDR_W)-1];
    logic              pl_we = 1'b0;
    logic [ADDR_W-1:0] pl_addr = '0;
    logic [7:0]        pl_data = '0;
    int                we_cnt = 0;
    int                done_cnt = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    logic [7:0]        last_data = '0;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (bus.we_o) mem[bus.addr_o] <= bus.wr_data_o;
        bus.rd_data_i <= mem[bus.addr_o];
        if (bus.we_o) begin
            we_cnt    <= we_cnt + 1;
            last_addr <= bus.addr_o;
            last_data <= bus.wr_data_o;
        end
        if (done) done_cnt <= done_cnt + 1;
    end

    int compared = 0;
    int mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_we   = 1'b1;
        cyc(1);
        pl_we   = 1'b0;
    endtask

    logic first_bit;

    // Clock n bits of tx out (wire order per build), capture miso at each rise
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        int idx;
        rx = 8'h00;
        for (int k = 0; k < n; k++) begin
`ifdef SPI_SLV_LSB_FIRST_EN
            idx = k;
`else
            idx = 7 - k;
`endif
            mosi = tx[idx];
            cyc(10);
            sclk = 1'b1;
            rx[idx] = miso;
            if (k == 0) first_bit = miso;
            cyc(10);
            sclk = 1'b0;
        end
    endtask

    logic [7:0] rx, rx1, rx2;
    int we0, done0;

    initial begin
        rst = 1'b0; en = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cyc(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_addr", bus.addr_o, 0);
        chk("rst_wdata", bus.wr_data_o, 0);
        chk("rst_we", bus.we_o, 0);
        chk("rst_cuenta", cuenta, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b1;
        cyc(5);

        // Single byte
        en = 1'b1;
        preload(0, 8'hA5);
        cs_n = 1'b0;
        cyc(10);
        chk("b1_busy", busy, 1);
        chk("b1_oe", miso_oe, 1);
        spi_bits(8'h3C, 8, rx);
        chk("b1_first_bit", first_bit, 1);
        chk("b1_rx", rx, 8'hA5);
        cyc(10);
        cs_n = 1'b1;
        cyc(10);
        chk("b1_we_cnt", we_cnt, 1);
        chk("b1_we_addr", last_addr, 0);
        chk("b1_we_data", last_data, 8'h3C);
        chk("b1_done", done_cnt, 1);
        chk("b1_cuenta", cuenta, 1);
        chk("b1_idle", busy, 0);

        // Three bytes back to back
        preload(0, 8'h11);
        preload(1, 8'h22);
        preload(2, 8'h33);
        cs_n = 1'b0;
        cyc(10);
        spi_bits(8'hDE, 8, rx);
        spi_bits(8'hAD, 8, rx1);
        spi_bits(8'hBE, 8, rx2);
        chk("b3_rx0", rx, 8'h11);
        chk("b3_rx1", rx1, 8'h22);
        chk("b3_rx2", rx2, 8'h33);
        cyc(10);
        cs_n = 1'b1;
        cyc(10);
        chk("b3_mem0", mem[0], 8'hDE);
        chk("b3_mem1", mem[1], 8'hAD);
        chk("b3_mem2", mem[2], 8'hBE);
        chk("b3_cuenta", cuenta, 3);
        chk("b3_we_cnt", we_cnt, 4);
        chk("b3_done", done_cnt, 2);

        // Abort after 5 bits of the second byte
        preload(0, 8'h55);
        preload(1, 8'h66);
        we0 = we_cnt; done0 = done_cnt;
        cs_n = 1'b0;
        cyc(10);
        spi_bits(8'h9A, 8, rx);
        chk("ab_rx0", rx, 8'h55);
        spi_bits(8'hFF, 5, rx);
        cyc(4);
        cs_n = 1'b1;
        cyc(10);
        chk("ab_we_cnt", we_cnt - we0, 1);
        chk("ab_mem0", mem[0], 8'h9A);
        chk("ab_mem1", mem[1], 8'h66);
        chk("ab_cuenta", cuenta, 1);
        chk("ab_done", done_cnt - done0, 1);
        chk("ab_idle", busy, 0);

        // Reset during bit 3
        preload(0, 8'h77);
        we0 = we_cnt;
        cs_n = 1'b0;
        cyc(10);
        spi_bits(8'hFF, 3, rx);
        cyc(5);
        rst = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_cuenta", cuenta, 0);
        chk("mr_oe", miso_oe, 0);
        chk("mr_miso", miso, 0);
        chk("mr_addr", bus.addr_o, 0);
        chk("mr_we", bus.we_o, 0);
        sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cyc(3);
        rst = 1'b1;
        cyc(5);
        chk("mr_no_we", we_cnt - we0, 0);
        cs_n = 1'b0;
        cyc(10);
        spi_bits(8'h42, 8, rx);
        cyc(10);
        cs_n = 1'b1;
        cyc(10);
        chk("mr_rx", rx, 8'h77);
        chk("mr_addr0", last_addr, 0);
        chk("mr_mem0", mem[0], 8'h42);
        chk("mr_cuenta1", cuenta, 1);

        // Disabled: full traffic ignored
        en = 1'b0;
        we0 = we_cnt; done0 = done_cnt;
        cs_n = 1'b0;
        cyc(10);
        chk("dis_oe", miso_oe, 0);
        chk("dis_busy", busy, 0);
        spi_bits(8'hC3, 8, rx);
        cyc(10);
        cs_n = 1'b1;
        cyc(10);
        chk("dis_we", we_cnt - we0, 0);
        chk("dis_done", done_cnt - done0, 0);
        chk("dis_cuenta", cuenta, 1);
        en = 1'b1;
        cyc(5);

`ifdef SPI_SLV_LSB_FIRST_EN
        // LSB-first build
        preload(0, 8'h01);
        cs_n = 1'b0;
        cyc(10);
        spi_bits(8'h80, 8, rx);
        cyc(10);
        cs_n = 1'b1;
        cyc(10);
        chk("lsb_first_bit", first_bit, 1);
        chk("lsb_rx", rx, 8'h01);
        chk("lsb_mem0", mem[0], 8'h80);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
